simon_stream_ctrl: RTL
======================

// Module: simon_stream_ctrl
// PURPOSE
//  Sequencer between a streaming block source/sink and one SIMON_128256 core. Buffers
//  plaintext/ciphertext blocks in a FIFO and holds the key. Drives the core's
//  newKey/loadKey/doneKey and newData/loadData/doneData/readData handshakes, one block at
//  a time. Returns results in order through a valid/ready output with a mode tag.
// PARAMETERS
//  N       64   word width; block = 2*N bits
//  M       4    key words; key = M*N bits
//  DEPTH   4    input FIFO entries, power of 2, >=2
//  TIMEOUT 1023 max cycles in any core-wait state before error
// PORTS
//  clk          in  1      clock, all logic on posedge
//  nR           in  1      reset, synchronous, active-low
//  in_valid     in  1      input block offered
//  in_ready     out 1      FIFO can accept (= !full)
//  in_block     in  2N     block, [2N-1:N]=word1, [N-1:0]=word0
//  in_enc_dec   in  1      1=encrypt, 0=decrypt, travels with block
//  key_valid    in  1      new key offered
//  key_ready    out 1      key accepted this cycle if key_valid
//  key_in       in  M*N    key, word i at [(i+1)N-1:iN]
//  out_valid    out 1      result held in output register
//  out_ready    in  1      sink takes result
//  out_block    out 2N     result block
//  out_enc_dec  out 1      mode the result was produced with
//  core_newKey  out 1      to core newKey
//  core_newData out 1      to core newData
//  core_readData out 1     to core readData
//  core_enc_dec out 1      to core enc_dec
//  core_BLOCK   out 2N     to core BLOCK
//  core_KEY     out M*N    to core KEY (key register)
//  core_loadKey/core_loadData/core_doneKey/core_doneData in 1 from core
//  core_outData in  2N     from core outData
//  busy         out 1      state != IDLE or FIFO non-empty
//  timeout_err  out 1      sticky; set on watchdog expiry
// BEHAVIOUR
//  Reset (nR=0 at posedge): state=IDLE, FIFO empty, key_loaded=0, key_pending=0,
//   out_valid=0, all core_* strobes 0, core_BLOCK/KEY=0, timeout_err=0, counter=0.
//   Core shares nR; reset mid-operation discards all queued and in-flight blocks.
//  FIFO: push on in_valid&&in_ready; pop only on loadData in LOAD. No bypass.
//   Full: in_ready=0, even if popping that cycle. Pointers wrap mod DEPTH.
//  key_ready=1 only in IDLE with key_pending=0. Accept copies key_in to key register.
//   Sets key_pending. A new key applies to every block loaded after acceptance.
//  FSM (registered outputs):
//   IDLE : key_pending -> KEY (priority over data); else if key_loaded && FIFO
//          non-empty && !out_valid -> LOAD; no key ever loaded -> blocks wait.
//   KEY  : core_newKey=1. On core_loadKey -> newKey=0 next cycle, -> KWAIT.
//   KWAIT: on core_doneKey -> key_loaded=1, key_pending=0, -> IDLE.
//   LOAD : core_BLOCK/core_enc_dec=FIFO head, core_newData=1. On core_loadData ->
//          pop, newData=0 next cycle, latch tag, -> RUN.
//   RUN  : on core_doneData -> capture core_outData+tag into output reg, out_valid=1,
//          core_readData=1, -> READ.
//   READ : hold readData=1 until core_doneData=0, then readData=0, -> IDLE.
//   ERR  : all core strobes 0; in_ready=key_ready=0; held until reset.
//  Output reg: out_valid cleared on out_ready; out_block/out_enc_dec stable while valid.
//   One block in flight; next LOAD waits until output reg is empty.
//  Watchdog: counter clears on state entry, increments each cycle in KEY/KWAIT/LOAD/RUN.
//   Reaching TIMEOUT -> timeout_err=1, -> ERR.
//  Latency: pop->out_valid = core latency + 1 cycle. Only one core strobe high at a time.
// TESTING
//  1 Key 1F1E..0100, enc, block 74206E69206D6F6F6D69732061207369 -> out 8D2B5579AFC8A3A03BF72A87EFE7B868,
//    out_enc_dec=1.
//  2 Enc 5 blocks back-to-back with out_ready=1 -> 5 outputs in push order. Decrypt them
//    (enc_dec=0) -> original plaintexts.
//  3 Fill FIFO with 4 blocks while out_ready=0 -> in_ready=0 at 4 queued+1 held.
//    Release out_ready -> order preserved, no loss.
//  4 Blocks pushed before any key -> no core_newData until key loaded. New key mid-stream
//    -> KEY runs before the next LOAD.
//  5 Stub core never raises doneData -> timeout_err=1 after TIMEOUT cycles in RUN.
//    nR=0 one cycle -> all outputs at reset values.
//  6 nR=0 during RUN with 3 queued -> FIFO empty, out_valid=0, key_loaded=0 after reset.

Source files
------------

// File: rtl/simon_stream_ctrl.sv
// Sequencer between a block stream and one SIMON_128256 core: input FIFO, key register,
// one-block-at-a-time core handshakes, in-order output register and a wait-state watchdog.
module simon_stream_ctrl #(
    parameter int N       = 64,
    parameter int M       = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             nR,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_block,
    input  logic             in_enc_dec,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [M*N-1:0]   key_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   out_block,
    output logic             out_enc_dec,
    output logic             core_newKey,
    output logic             core_newData,
    output logic             core_readData,
    output logic             core_enc_dec,
    output logic [2*N-1:0]   core_BLOCK,
    output logic [M*N-1:0]   core_KEY,
    input  logic             core_loadKey,
    input  logic             core_loadData,
    input  logic             core_doneKey,
    input  logic             core_doneData,
    input  logic [2*N-1:0]   core_outData,
    output logic             busy,
    output logic             timeout_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_KEY   = 3'd1;
    localparam logic [2:0] S_KWAIT = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_RUN   = 3'd4;
    localparam logic [2:0] S_READ  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]     state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [M*N-1:0] key_q, key_d;
    logic           key_loaded_q, key_loaded_d;
    logic           key_pending_q, key_pending_d;
    logic           new_key_q, new_key_d;
    logic           new_data_q, new_data_d;
    logic           read_data_q, read_data_d;
    logic [2*N-1:0] blk_q, blk_d;
    logic           enc_q, enc_d;
    logic           tag_q, tag_d;
    logic           out_valid_q, out_valid_d;
    logic [2*N-1:0] out_block_q, out_block_d;
    logic           out_enc_dec_q, out_enc_dec_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_err_q, timeout_err_d;

    logic [2*N:0]   fifo_mem [DEPTH];
    logic [2*N:0]   head;
    logic           fifo_empty, fifo_full, push, pop, key_accept, wait_state;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head       = fifo_mem[rd_ptr_q[AW-1:0]];
    assign in_ready   = !fifo_full && (state_q != S_ERR);
    assign key_ready  = (state_q == S_IDLE) && !key_pending_q;
    assign push       = in_valid && in_ready;
    assign key_accept = key_valid && key_ready;
    assign wait_state = (state_q == S_KEY) || (state_q == S_KWAIT) ||
                        (state_q == S_LOAD) || (state_q == S_RUN);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        key_d         = key_q;
        key_loaded_d  = key_loaded_q;
        key_pending_d = key_pending_q;
        new_key_d     = new_key_q;
        new_data_d    = new_data_q;
        read_data_d   = read_data_q;
        blk_d         = blk_q;
        enc_d         = enc_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        out_block_d   = out_block_q;
        out_enc_dec_d = out_enc_dec_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = wait_state ? cnt_q + CW'(1) : cnt_q;
        pop           = 1'b0;

        if (key_accept) begin
            key_d         = key_in;
            key_pending_d = 1'b1;
        end
        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A key accepted this cycle must apply to the next block, so it blocks LOAD too.
                if (key_pending_q) begin
                    state_d   = S_KEY;
                    new_key_d = 1'b1;
                end else if (key_loaded_q && !fifo_empty && !out_valid_q && !key_accept) begin
                    state_d    = S_LOAD;
                    new_data_d = 1'b1;
                    blk_d      = head[2*N-1:0];
                    enc_d      = head[2*N];
                end
            end
            S_KEY: if (core_loadKey) begin
                new_key_d = 1'b0;
                state_d   = S_KWAIT;
            end
            S_KWAIT: if (core_doneKey) begin
                key_loaded_d  = 1'b1;
                key_pending_d = 1'b0;
                state_d       = S_IDLE;
            end
            S_LOAD: if (core_loadData) begin
                pop        = 1'b1;
                new_data_d = 1'b0;
                tag_d      = enc_q;
                state_d    = S_RUN;
            end
            S_RUN: if (core_doneData) begin
                out_block_d   = core_outData;
                out_enc_dec_d = tag_q;
                out_valid_d   = 1'b1;
                read_data_d   = 1'b1;
                state_d       = S_READ;
            end
            S_READ: if (!core_doneData) begin
                read_data_d = 1'b0;
                state_d     = S_IDLE;
            end
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase

        // Watchdog only fires when the core has not answered on its last allowed cycle.
        if (wait_state && (state_d == state_q) && (cnt_q == CW'(TIMEOUT - 1))) begin
            state_d       = S_ERR;
            timeout_err_d = 1'b1;
            new_key_d     = 1'b0;
            new_data_d    = 1'b0;
            read_data_d   = 1'b0;
        end
        if (state_d != state_q) cnt_d = '0;

        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!nR) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            key_q         <= '0;
            key_loaded_q  <= 1'b0;
            key_pending_q <= 1'b0;
            new_key_q     <= 1'b0;
            new_data_q    <= 1'b0;
            read_data_q   <= 1'b0;
            blk_q         <= '0;
            enc_q         <= 1'b0;
            tag_q         <= 1'b0;
            out_valid_q   <= 1'b0;
            out_block_q   <= '0;
            out_enc_dec_q <= 1'b0;
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            key_q         <= key_d;
            key_loaded_q  <= key_loaded_d;
            key_pending_q <= key_pending_d;
            new_key_q     <= new_key_d;
            new_data_q    <= new_data_d;
            read_data_q   <= read_data_d;
            blk_q         <= blk_d;
            enc_q         <= enc_d;
            tag_q         <= tag_d;
            out_valid_q   <= out_valid_d;
            out_block_q   <= out_block_d;
            out_enc_dec_q <= out_enc_dec_d;
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= {in_enc_dec, in_block};
    end

    assign out_valid     = out_valid_q;
    assign out_block     = out_block_q;
    assign out_enc_dec   = out_enc_dec_q;
    assign core_newKey   = new_key_q;
    assign core_newData  = new_data_q;
    assign core_readData = read_data_q;
    assign core_enc_dec  = enc_q;
    assign core_BLOCK    = blk_q;
    assign core_KEY      = key_q;
    assign busy          = (state_q != S_IDLE) || !fifo_empty;
    assign timeout_err   = timeout_err_q;
endmodule
